// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter for the shared packet SRAM read port, with per-port frame lock
// and a latency-matched return pipe that steers rvalid back to the issuing port.
module sram_read_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 12,
    parameter int BLOCK_BITS = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              re_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  raddr_i,
    input  logic [NUM_PORTS-1:0]              lock_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [BLOCK_BITS-1:0]             rdata_o,
    output logic                              sram_re_o,
    output logic [ADDR_W-1:0]                 sram_addr_o,
    input  logic [BLOCK_BITS-1:0]             sram_rdata_i
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  lock_vld_q, lock_vld_d;
    logic [PW-1:0]         lock_own_q, lock_own_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [RD_LATENCY-1:0] pv_q;
    logic [PW-1:0]         pid_q [RD_LATENCY];

    logic                  win_vld;
    logic [PW-1:0]         win_idx;

    // Winner selection; iterating downward leaves the first requester at or after rr_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        if (lock_vld_q) begin
            if (re_i[lock_own_q]) begin
                win_vld = 1'b1;
                win_idx = lock_own_q;
            end
        end else begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                if (re_i[PW'((int'(rr_ptr_q) + k) % NUM_PORTS)]) begin
                    win_vld = 1'b1;
                    win_idx = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        addr_d     = addr_q;
        if (win_vld) begin
            rr_ptr_d   = PW'((int'(win_idx) + 1) % NUM_PORTS);
            lock_vld_d = lock_i[win_idx];
            lock_own_d = win_idx;
            addr_d     = raddr_i[win_idx];
        end else if (lock_vld_q && !re_i[lock_own_q] && !lock_i[lock_own_q]) begin
            // Owner walked away without a final locked access.
            lock_vld_d = 1'b0;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (win_vld) begin
            gnt_o[win_idx] = 1'b1;
        end
        sram_re_o   = win_vld;
        sram_addr_o = win_vld ? raddr_i[win_idx] : addr_q;
        rdata_o     = sram_rdata_i;
        rvalid_o    = '0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            rvalid_o[q] = pv_q[RD_LATENCY-1] && (pid_q[RD_LATENCY-1] == PW'(q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
            addr_q     <= '0;
            pv_q       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pid_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            addr_q     <= addr_d;
            pv_q[0]    <= win_vld;
            pid_q[0]   <= win_idx;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pid_q[i] <= pid_q[i-1];
            end
        end
    end
endmodule
